// File: rtl/mycpu_pkg.sv
// Shared encodings and SRAM-like bus widths for the CPU memory-side blocks.
// Used by sram_bus_arbiter and arb_owner_fifo.
package mycpu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int SIZE_W = 2;

  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD_I = 2'd1,
    ST_HOLD_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    owner_e owner;
    logic   discard;
  } owner_entry_t;

  function automatic arb_state_e hold_state(input owner_e o);
    return (o == OWN_DATA) ? ST_HOLD_D : ST_HOLD_I;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order owner FIFO: one {owner, discard} entry per accepted address phase.
// discard_inst_i marks every stored inst entry so its return is absorbed.
module arb_owner_fifo
  import mycpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push_i,
  input  owner_entry_t                   push_entry_i,
  input  logic                           pop_i,
  input  logic                           discard_inst_i,
  output owner_entry_t                   head_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  owner_entry_t    entry_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = entry_q[rd_ptr_q];

  // A pop on an empty FIFO is a stray return and is dropped here.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '{owner: OWN_INST, discard: 1'b0};
      end
    end else begin
      if (discard_inst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (entry_q[i].owner == OWN_INST) begin
            entry_q[i].discard <= 1'b1;
          end
        end
      end
      if (push_ok) begin
        entry_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between inst fetch and data requesters, routing returns in order.
// ARB_ROUND_ROBIN_EN selects round-robin instead of data-first arbitration in IDLE.
module sram_bus_arbiter
  import mycpu_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              inst_cancel,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state_o,
  output logic [2:0]        dbg_count_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  // Handshake: an address phase transfers on the cycle where req && addr_ok are both high;
  // a requester keeps req and its payload stable until it sees its addr_ok. Returns are
  // single-cycle data_ok pulses, delivered in acceptance order, with no back-pressure.

  arb_state_e   state_q;
  owner_e       win_owner;
  logic         win_valid;
  logic         accept;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  owner_entry_t head;
  owner_entry_t push_entry;
  logic         ret_valid;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e       last_q;
`endif

  always_comb begin
    win_valid = 1'b0;
    win_owner = OWN_INST;
    unique case (state_q)
      ST_HOLD_I: begin
        win_valid = inst_req;
        win_owner = OWN_INST;
      end
      ST_HOLD_D: begin
        win_valid = data_req;
        win_owner = OWN_DATA;
      end
      default: begin
        win_valid = inst_req || data_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_req && data_req) begin
          win_owner = (last_q == OWN_DATA) ? OWN_INST : OWN_DATA;
        end else begin
          win_owner = data_req ? OWN_DATA : OWN_INST;
        end
`else
        // Data first: it belongs to an older instruction, so MEM never starves behind IF.
        win_owner = data_req ? OWN_DATA : OWN_INST;
`endif
      end
    endcase
  end

  // Gated on the registered count only, so data_ok never feeds back into req.
  assign mem_req = win_valid && !fifo_full;
  assign accept  = mem_req && mem_addr_ok;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (win_valid) begin
      if (win_owner == OWN_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
      end else begin
        mem_size  = SIZE_WORD;
        mem_addr  = inst_addr;
      end
    end
  end

  assign inst_addr_ok = accept && (win_owner == OWN_INST);
  assign data_addr_ok = accept && (win_owner == OWN_DATA);

  assign push_entry.owner   = win_owner;
  assign push_entry.discard = (win_owner == OWN_INST) && inst_cancel;

  arb_owner_fifo #(
    .DEPTH(MAX_OUTST)
  ) u_owner_fifo (
    .clk           (clk),
    .resetn        (resetn),
    .push_i        (accept),
    .push_entry_i  (push_entry),
    .pop_i         (mem_data_ok),
    .discard_inst_i(inst_cancel),
    .head_o        (head),
    .empty_o       (fifo_empty),
    .full_o        (fifo_full),
    .count_o       (fifo_count)
  );

  assign ret_valid    = mem_data_ok && !fifo_empty;
  assign data_data_ok = ret_valid && (head.owner == OWN_DATA);
  assign inst_data_ok = ret_valid && (head.owner == OWN_INST) && !head.discard && !inst_cancel;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign dbg_state_o = state_q;
  assign dbg_count_o = 3'(fifo_count);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= OWN_INST;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_valid && !accept) begin
            state_q <= hold_state(win_owner);
          end
        end
        ST_HOLD_I, ST_HOLD_D: begin
          if (accept) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
`ifdef ARB_ROUND_ROBIN_EN
      if (accept) begin
        last_q <= win_owner;
      end
`endif
    end
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares the single SRAM-like memory port between the instruction-fetch requester (pre-IF/IF stages) and the data requester (EXE/MEM stages). Grants one address phase at a time, records the owner of every accepted transaction in an in-order owner FIFO, and routes each `data_ok`/`rdata` return to its owner. An instruction-flush input tags outstanding fetches so their returns are absorbed, not forwarded. Sits between the pipeline and the SRAM-to-AXI bridge in `mycpu_top`.

## Interface
- `MAX_OUTST`, 2: maximum accepted-but-unreturned transactions (1..4).
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `inst_req` in 1; `inst_addr` in 32: fetch request and address (read-only, size 2, word).
- `inst_addr_ok` out 1; `inst_data_ok` out 1; `inst_rdata` out 32: fetch handshake and return.
- `inst_cancel` in 1: one-cycle flush pulse (`ws_ex || ws_eret`).
- `data_req` in 1; `data_wr` in 1; `data_size` in 2; `data_addr` in 32; `data_wstrb` in 4; `data_wdata` in 32: data request.
- `data_addr_ok` out 1; `data_data_ok` out 1; `data_rdata` out 32: data handshake and return.
- `mem_req` out 1; `mem_wr` out 1; `mem_size` out 2; `mem_addr` out 32; `mem_wstrb` out 4; `mem_wdata` out 32: downstream request.
- `mem_addr_ok` in 1; `mem_data_ok` in 1; `mem_rdata` in 32: downstream handshake and return.

## Operation
- States: `IDLE`, `HOLD_I`, `HOLD_D`. An address phase is accepted on `mem_req && mem_addr_ok`.
- `IDLE`: selects a winner among the active requests. The winner drives `mem_*` in the same cycle. If the phase is accepted, stay in `IDLE`. Otherwise go to `HOLD_I` or `HOLD_D`.
- `HOLD_x`: the grant stays locked to x until acceptance, then returns to `IDLE`. The other requester is not granted while locked.
- Inst grant drives `mem_wr=0`, `mem_size=2`, `mem_wstrb=0`, `mem_wdata=0`.
- `mem_req` = granted request AND owner FIFO not full. A full FIFO blocks issue even if `mem_data_ok` pops in the same cycle, so there is no combinational data_ok→req path.
- `x_addr_ok = mem_addr_ok && mem_req && grant==x`.
- Owner FIFO push on acceptance. The entry is {owner, discard}. Depth is `MAX_OUTST`; a count tracks occupancy.
- Owner FIFO pop on `mem_data_ok`. The head entry selects the destination:
  - data owner: `data_data_ok=1`.
  - inst owner with discard=0: `inst_data_ok=1`.
  - inst owner with discard=1: both outputs stay 0 and the return is absorbed.
- `inst_rdata` and `data_rdata` are both `mem_rdata`, with no gating.
- `inst_cancel` sets discard on every inst entry in the FIFO, including an inst entry pushed in the same cycle.
- A held, not-yet-accepted inst request is not aborted; its returned data is forwarded.
- `inst_data_ok` is forced to 0 in the cancel cycle itself.
- `mem_data_ok` with an empty FIFO is a protocol error: ignored, no pop, count does not underflow.

## Timing
- Reset: all outputs 0 except the rdata pass-throughs. FIFO empty, state `IDLE`, RR pointer = inst.
- Zero-cycle request path: `x_req` → `mem_req` and `mem_addr_ok` → `x_addr_ok` are combinational.
- Zero-cycle return path: `mem_data_ok` → `x_data_ok` is combinational from the registered FIFO head.
- Back-to-back acceptances are allowed every cycle until full.
- A pop and a push in the same cycle leave count unchanged.
- Reset asserted mid-transaction clears the FIFO and state immediately. Returns arriving afterward hit the empty-FIFO rule.

## Configuration
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority in `IDLE`, data wins over inst (older instruction first, no deadlock with a stalled MEM stage).
- `ARB_ROUND_ROBIN_EN` defined: when both request in `IDLE`, the requester not granted last wins. The pointer updates on each acceptance.
- Lock/hold behaviour is identical in both builds.

## Structure
- Shared package `mycpu_pkg` holds:
  - owner encoding (`OWN_INST=0`, `OWN_DATA=1`);
  - state encoding;
  - SRAM bus widths (addr 32, data 32, strb 4, size 2).
- Sub-module `arb_owner_fifo`: circular FIFO of {owner, discard}. Wrap-around read/write pointers, count, full/empty, plus a bulk "mark all inst entries discard" port.
- The top module holds the grant FSM, RR pointer and muxing.

## Test plan
- Both request at reset release with `mem_addr_ok=1`, fixed priority → data accepted at cycle 0, inst at cycle 1, `mem_addr` order D then I.
- `data_req` held while `mem_addr_ok=0` for 3 cycles and `inst_req` raised during the wait → `mem_addr` stays the data address, `inst_addr_ok=0` until the data acceptance; inst is accepted the next cycle.
- Issue inst to 0xBFC00000 then data, with `MAX_OUTST=2` and no returns → the third request is blocked (`mem_req=0`). Two `mem_data_ok` pulses produce `inst_data_ok` then `data_data_ok`; issue resumes after the first pop.
- Two inst fetches outstanding, pulse `inst_cancel`, return both with rdata 0x24020001/0x24020002 → `inst_data_ok` stays 0 on both and the FIFO is empty afterwards.
- Stray `mem_data_ok` with the FIFO empty → no `x_data_ok`, count stays 0.
- `ARB_ROUND_ROBIN_EN` defined, both requesting continuously → grants alternate D, I, D, I over 4 cycles.
